// File: rtl/mem_board_keeper.sv
// Board keeper for the memory game: holds the 16-card layout, reveal/match masks,
// active player and pair counts, and sequences reveal, match-lock, mismatch-hide and game end.
module mem_board_keeper #(
   parameter int unsigned N_CARDS    = 16,
   parameter int unsigned HIDE_DELAY = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] layout_in,
   input  logic [7:0]  cursor,
   input  logic        select,
   input  logic        time_up,
   input  logic [1:0]  result,
   input  logic        par,
   input  logic [7:0]  sel1,
   input  logic [7:0]  sel2,
   output logic [3:0]  card_value,
   output logic        empty,
   output logic        player,
   output logic [15:0] revealed,
   output logic [15:0] matched,
   output logic [3:0]  pairs_j1,
   output logic [3:0]  pairs_j2,
   output logic        busy,
   output logic        game_over,
   output logic        tie
);

   localparam int unsigned CW = $clog2(HIDE_DELAY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK1,
      S_PICK2,
      S_SHOW,
      S_DONE
   } state_t;

   state_t        state;
   logic [63:0]   layout_q;
   logic          pick_d;
   logic          pick_evt;
   logic [1:0]    result_d;
   logic [CW-1:0] cnt;

   logic          pick_raw;
   logic [3:0]    cur_idx;
   logic          cur_in_range;
   logic          sel_valid;
   logic          is_match;
   logic [15:0]   pair_bits;
   logic [15:0]   mat_next;
   logic          res_evt;
   logic          res_end;
   logic          room;
   logic [3:0]    j1_next;
   logic [3:0]    j2_next;

   // Cursor lookup is combinational so the front end sees it with zero latency
   assign pick_raw     = select | time_up;
   assign cur_idx      = cursor[3:0];
   assign cur_in_range = cursor < 8'(N_CARDS);
   assign card_value   = cur_in_range ? layout_q[{cur_idx, 2'b00} +: 4] : 4'd0;
   assign empty        = cur_in_range && !matched[cur_idx] && !revealed[cur_idx] &&
                         ((state == S_PICK1) || (state == S_PICK2));

   assign sel_valid = (sel1 < 8'(N_CARDS)) && (sel2 < 8'(N_CARDS)) && (sel1 != sel2);
   assign is_match  = par && sel_valid && !matched[sel1[3:0]] && !matched[sel2[3:0]];
   assign pair_bits = (16'd1 << sel1[3:0]) | (16'd1 << sel2[3:0]);
   assign mat_next  = matched | pair_bits;
   assign res_evt   = (result == 2'b01) && (result_d != 2'b01);
   assign res_end   = result[1];
   assign room      = (5'(pairs_j1) + 5'(pairs_j2)) < 5'd8;

   // Counts after crediting the active player, capped so the total never passes 8
   always_comb begin
      j1_next = pairs_j1;
      j2_next = pairs_j2;
      if (room) begin
         if (player) j2_next = pairs_j2 + 4'd1;
         else        j1_next = pairs_j1 + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         layout_q  <= '0;
         pick_d    <= 1'b0;
         pick_evt  <= 1'b0;
         result_d  <= 2'b00;
         cnt       <= '0;
         player    <= 1'b0;
         revealed  <= '0;
         matched   <= '0;
         pairs_j1  <= '0;
         pairs_j2  <= '0;
         busy      <= 1'b0;
         game_over <= 1'b0;
         tie       <= 1'b0;
      end else begin
         pick_d   <= pick_raw;
         pick_evt <= pick_raw & ~pick_d;
         result_d <= result;
         if (load) begin
            layout_q  <= layout_in;
            state     <= S_PICK1;
            cnt       <= '0;
            player    <= 1'b0;
            revealed  <= '0;
            matched   <= '0;
            pairs_j1  <= '0;
            pairs_j2  <= '0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            tie       <= 1'b0;
         end else if (state != S_IDLE && res_end) begin
            state     <= S_DONE;
            cnt       <= '0;
            revealed  <= '0;
            busy      <= 1'b0;
            game_over <= 1'b1;
            tie       <= (pairs_j1 == pairs_j2);
         end else begin
            case (state)
               S_PICK1: begin
                  if (pick_evt) begin
                     if (empty) revealed[cur_idx] <= 1'b1;
                     state <= S_PICK2;
                  end
               end
               S_PICK2: begin
                  if (res_evt) begin
                     if (is_match) begin
                        matched  <= mat_next;
                        pairs_j1 <= j1_next;
                        pairs_j2 <= j2_next;
                        if (mat_next == '1) begin
                           state     <= S_DONE;
                           revealed  <= '0;
                           game_over <= 1'b1;
                           tie       <= (j1_next == j2_next);
                        end else begin
                           state    <= S_PICK1;
                           revealed <= revealed & ~pair_bits;
                        end
                     end else begin
                        state <= S_SHOW;
                        busy  <= 1'b1;
                        cnt   <= CW'(HIDE_DELAY - 1);
                     end
                  end else if (pick_evt && empty) begin
                     revealed[cur_idx] <= 1'b1;
                  end
               end
               // Mismatched pair stays up for the full delay, then the turn passes
               S_SHOW: begin
                  if (cnt == '0) begin
                     state    <= S_PICK1;
                     revealed <= '0;
                     player   <= ~player;
                     busy     <= 1'b0;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_board_keeper.sv
// Self-checking bench for mem_board_keeper: directed scenarios plus randomized turns
// compared against a transaction-level model of the game rules.
module tb_mem_board_keeper;

   localparam int unsigned D = 4;
   localparam int P_IDLE = 0, P_PICK1 = 1, P_PICK2 = 2, P_SHOW = 3, P_DONE = 4;

   logic        clk;
   logic        rst;
   logic        load;
   logic [63:0] layout_in;
   logic [7:0]  cursor;
   logic        select;
   logic        time_up;
   logic [1:0]  result;
   logic        par;
   logic [7:0]  sel1;
   logic [7:0]  sel2;
   logic [3:0]  card_value;
   logic        empty;
   logic        player;
   logic [15:0] revealed;
   logic [15:0] matched;
   logic [3:0]  pairs_j1;
   logic [3:0]  pairs_j2;
   logic        busy;
   logic        game_over;
   logic        tie;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [3:0]  m_lay [16];
   logic [15:0] m_rev, m_mat;
   logic [3:0]  m_j1, m_j2;
   logic        m_player;
   int          m_phase;

   wire [43:0] dut_vec = {revealed, matched, pairs_j1, pairs_j2, player, busy, game_over, tie};

   mem_board_keeper #(.N_CARDS(16), .HIDE_DELAY(D)) dut (
      .clk(clk), .rst(rst), .load(load), .layout_in(layout_in), .cursor(cursor),
      .select(select), .time_up(time_up), .result(result), .par(par),
      .sel1(sel1), .sel2(sel2), .card_value(card_value), .empty(empty),
      .player(player), .revealed(revealed), .matched(matched),
      .pairs_j1(pairs_j1), .pairs_j2(pairs_j2), .busy(busy),
      .game_over(game_over), .tie(tie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [43:0] model_vec();
      return {m_rev, m_mat, m_j1, m_j2, m_player, (m_phase == P_SHOW), (m_phase == P_DONE),
              (m_phase == P_DONE) && (m_j1 == m_j2)};
   endfunction

   function automatic bit model_empty(input int idx);
      if (idx < 0 || idx > 15) return 1'b0;
      return (m_phase == P_PICK1 || m_phase == P_PICK2) && !m_mat[idx[3:0]] && !m_rev[idx[3:0]];
   endfunction

   function automatic logic [3:0] model_value(input int idx);
      if (idx < 0 || idx > 15) return 4'd0;
      return m_lay[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_lay[i] = 4'd0;
      m_rev = '0; m_mat = '0; m_j1 = '0; m_j2 = '0; m_player = 1'b0; m_phase = P_IDLE;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [63:0] lay);
      layout_in = lay;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 16; i++) m_lay[i] = lay[4*i +: 4];
      m_rev = '0; m_mat = '0; m_j1 = '0; m_j2 = '0; m_player = 1'b0; m_phase = P_PICK1;
   endtask

   task automatic do_pick(input int idx, input bit to);
      bit av;
      cursor = 8'(idx);
      av = model_empty(idx);
      if (to) time_up = 1'b1; else select = 1'b1;
      step();
      select = 1'b0;
      time_up = 1'b0;
      step();
      step();
      if (m_phase == P_PICK1 || m_phase == P_PICK2) begin
         if (av) m_rev[idx[3:0]] = 1'b1;
         m_phase = P_PICK2;
      end
   endtask

   task automatic do_result(input logic [1:0] code, input bit p, input int s1, input int s2);
      logic [15:0] bits;
      par = p; sel1 = 8'(s1); sel2 = 8'(s2); result = code;
      step();
      result = 2'b00; par = 1'b0;
      if (code[1]) begin
         if (m_phase != P_IDLE) begin m_phase = P_DONE; m_rev = '0; end
      end else if (code == 2'b01 && m_phase == P_PICK2) begin
         if (p && s1 != s2 && s1 >= 0 && s1 < 16 && s2 >= 0 && s2 < 16 &&
             !m_mat[s1[3:0]] && !m_mat[s2[3:0]]) begin
            bits = '0;
            bits[s1[3:0]] = 1'b1;
            bits[s2[3:0]] = 1'b1;
            m_mat = m_mat | bits;
            m_rev = m_rev & ~bits;
            if (int'(m_j1) + int'(m_j2) < 8) begin
               if (m_player) m_j2 = m_j2 + 4'd1; else m_j1 = m_j1 + 4'd1;
            end
            if (m_mat == 16'hFFFF) begin m_phase = P_DONE; m_rev = '0; end
            else m_phase = P_PICK1;
         end else begin
            m_phase = P_SHOW;
         end
      end
   endtask

   task automatic wait_show(output int n, input bit poke);
      n = 0;
      while (busy === 1'b1 && n < int'(D) + 8) begin
         if (poke && n == 0) begin cursor = 8'($urandom_range(15, 0)); select = 1'b1; end
         n++;
         step();
         select = 1'b0;
      end
      if (m_phase == P_SHOW) begin m_rev = '0; m_player = ~m_player; m_phase = P_PICK1; end
   endtask

   function automatic logic [63:0] rand_layout();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      step(); step();
      cursor = 8'd5; #1;
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL reset_outputs: got %h expected %h", dut_vec, model_vec()); end
      checks++;
      if (card_value !== 4'd0 || empty !== 1'b0) begin failures++;
         $display("FAIL reset_cursor: got value=%h empty=%b expected 0/0", card_value, empty); end
      rst = 1'b1;
      step(); step();
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL idle_no_load: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic test_load();
      logic [63:0] lay;
      for (int i = 0; i < 16; i++) lay[4*i +: 4] = 4'(i >> 1);
      do_load(lay);
      cursor = 8'd5; #1;
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL load_state: got %h expected %h", dut_vec, model_vec()); end
      checks++;
      if (card_value !== 4'd2 || empty !== 1'b1) begin failures++;
         $display("FAIL load_cursor5: got value=%h empty=%b expected 2/1", card_value, empty); end
   endtask

   task automatic test_match();
      do_pick(2, 1'b0);
      do_pick(3, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL match_reveal: got %h expected %h", dut_vec, model_vec()); end
      do_result(2'b01, 1'b1, 2, 3);
      checks++;
      if (matched !== 16'h000C || pairs_j1 !== 4'd1 || player !== 1'b0 || dut_vec !== model_vec()) begin
         failures++;
         $display("FAIL match_lock: got %h expected %h", dut_vec, model_vec()); end
      cursor = 8'd2; #1;
      checks++;
      if (empty !== 1'b0) begin failures++;
         $display("FAIL match_empty: got %b expected 0", empty); end
   endtask

   task automatic test_mismatch();
      int n;
      do_pick(0, 1'b0);
      do_pick(5, 1'b0);
      do_result(2'b01, 1'b0, 0, 5);
      checks++;
      if (revealed !== 16'h0021 || busy !== 1'b1 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL mismatch_show: got %h expected %h", dut_vec, model_vec()); end
      wait_show(n, 1'b1);
      checks++;
      if (n != int'(D)) begin failures++;
         $display("FAIL mismatch_busy_len: got %0d expected %0d", n, D); end
      checks++;
      if (revealed !== 16'h0 || player !== 1'b1 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL mismatch_hide: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic test_bogus();
      int n;
      do_pick(6, 1'b0);
      do_pick(7, 1'b0);
      do_result(2'b01, 1'b1, 7, 7);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL bogus_same: got %h expected %h", dut_vec, model_vec()); end
      wait_show(n, 1'b0);
      checks++;
      if (n != int'(D) || dut_vec !== model_vec()) begin failures++;
         $display("FAIL bogus_same_hide: got n=%0d %h expected n=%0d %h", n, dut_vec, D, model_vec()); end
      do_pick(6, 1'b0);
      do_pick(8, 1'b0);
      do_result(2'b01, 1'b1, 20, 8);
      checks++;
      if (busy !== 1'b1 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL bogus_range: got %h expected %h", dut_vec, model_vec()); end
      wait_show(n, 1'b0);
      checks++;
      if (n != int'(D) || dut_vec !== model_vec()) begin failures++;
         $display("FAIL bogus_range_hide: got n=%0d %h expected n=%0d %h", n, dut_vec, D, model_vec()); end
   endtask

   task automatic test_result_end();
      do_load(rand_layout());
      do_pick(4, 1'b0);
      do_result(2'b10, 1'b0, 0, 0);
      checks++;
      if (game_over !== 1'b1 || tie !== 1'b1 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL winner_early: got %h expected %h", dut_vec, model_vec()); end
      do_pick(9, 1'b0);
      do_result(2'b01, 1'b1, 1, 2);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL done_frozen: got %h expected %h", dut_vec, model_vec()); end
      do_load(rand_layout());
      do_pick(0, 1'b0);
      do_pick(1, 1'b0);
      do_result(2'b01, 1'b1, 0, 1);
      do_pick(2, 1'b0);
      do_result(2'b11, 1'b0, 0, 0);
      checks++;
      if (game_over !== 1'b1 || tie !== 1'b0 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL tie_code_uneven: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic test_full_game();
      int pos [16];
      bit want [8];
      int n, j, t;
      bit tb;
      logic [63:0] lay;
      for (int i = 0; i < 16; i++) pos[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(i, 0); t = pos[i]; pos[i] = pos[j]; pos[j] = t;
      end
      for (int i = 0; i < 8; i++) want[i] = (i < 4);
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(i, 0); tb = want[i]; want[i] = want[j]; want[j] = tb;
      end
      lay = '0;
      for (int v = 0; v < 8; v++) begin
         lay[4*pos[2*v] +: 4] = 4'(v);
         lay[4*pos[2*v+1] +: 4] = 4'(v);
      end
      do_load(lay);
      for (int k = 0; k < 8; k++) begin
         if (m_player != logic'(want[k])) begin
            do_pick(pos[2*k], 1'b0);
            do_pick(pos[2*k+1], 1'b1);
            do_result(2'b01, 1'b0, pos[2*k], pos[2*k+1]);
            wait_show(n, 1'b0);
            checks++;
            if (n != int'(D)) begin failures++;
               $display("FAIL game_pass_turn: got %0d expected %0d", n, D); end
         end
         do_pick(pos[2*k], 1'b0);
         do_pick(pos[2*k+1], 1'b0);
         do_result(2'b01, 1'b1, pos[2*k], pos[2*k+1]);
         checks++;
         if (dut_vec !== model_vec()) begin failures++;
            $display("FAIL game_pair%0d: got %h expected %h", k, dut_vec, model_vec()); end
      end
      checks++;
      if ({game_over, tie} !== 2'b11 || pairs_j1 !== 4'd4 || pairs_j2 !== 4'd4) begin failures++;
         $display("FAIL game_end_tie: got over=%b tie=%b j1=%0d j2=%0d expected 1 1 4 4",
                  game_over, tie, pairs_j1, pairs_j2); end
   endtask

   task automatic test_random_turns();
      int a, b, s1, s2, n, c;
      bit p;
      do_load(rand_layout());
      for (int it = 0; it < 30; it++) begin
         a = $urandom_range(19, 0);
         b = $urandom_range(19, 0);
         do_pick(a, ($urandom_range(4, 0) == 0));
         do_pick(b, ($urandom_range(4, 0) == 0));
         c = $urandom_range(31, 0);
         cursor = 8'(c); #1;
         checks++;
         if (card_value !== model_value(c) || empty !== model_empty(c)) begin failures++;
            $display("FAIL rand_cursor%0d: got value=%h empty=%b expected %h/%b",
                     c, card_value, empty, model_value(c), model_empty(c)); end
         s1 = ($urandom_range(7, 0) == 0) ? int'($urandom_range(23, 0)) : a;
         s2 = ($urandom_range(7, 0) == 0) ? int'($urandom_range(23, 0)) : b;
         p = ($urandom_range(1, 0) == 1);
         do_result(2'b01, p, s1, s2);
         checks++;
         if (dut_vec !== model_vec()) begin failures++;
            $display("FAIL rand_turn%0d: got %h expected %h", it, dut_vec, model_vec()); end
         if (m_phase == P_SHOW) begin
            wait_show(n, 1'b1);
            checks++;
            if (n != int'(D) || dut_vec !== model_vec()) begin failures++;
               $display("FAIL rand_show%0d: got n=%0d %h expected n=%0d %h",
                        it, n, dut_vec, D, model_vec()); end
         end
      end
   endtask

   task automatic test_interrupts();
      do_load(rand_layout());
      do_pick(0, 1'b0);
      do_pick(1, 1'b0);
      do_result(2'b01, 1'b0, 0, 1);
      step(); step();
      do_load(rand_layout());
      checks++;
      if (busy !== 1'b0 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL load_in_show: got %h expected %h", dut_vec, model_vec()); end
      do_pick(4, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL pick_after_reload: got %h expected %h", dut_vec, model_vec()); end
      rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== 44'h0 || dut_vec !== model_vec()) begin failures++;
         $display("FAIL async_reset: got %h expected %h", dut_vec, model_vec()); end
      step();
      rst = 1'b1;
      step(); step();
      cursor = 8'd3; #1;
      checks++;
      if (card_value !== model_value(3) || empty !== 1'b0) begin failures++;
         $display("FAIL reset_layout_gone: got value=%h empty=%b expected %h/0",
                  card_value, empty, model_value(3)); end
      do_pick(3, 1'b0);
      do_result(2'b01, 1'b1, 3, 4);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL idle_ignores: got %h expected %h", dut_vec, model_vec()); end
      do_load(rand_layout());
      do_pick(3, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin failures++;
         $display("FAIL restart_after_reset: got %h expected %h", dut_vec, model_vec()); end
   endtask

   initial begin
      rst = 1'b0; load = 1'b0; layout_in = '0; cursor = '0; select = 1'b0; time_up = 1'b0;
      result = 2'b00; par = 1'b0; sel1 = '0; sel2 = '0;
      model_reset();
      test_reset();
      test_load();
      test_match();
      test_mismatch();
      test_bogus();
      test_result_end();
      test_full_game();
      test_random_turns();
      test_interrupts();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
